draw_arbiter: RTL

DRAW_ARBITER -- requirements
Module: draw_arbiter

---
 rtl/draw_arbiter_pkg.sv | 15 +
 rtl/draw_watchdog.sv | 20 ++
 rtl/draw_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/draw_arbiter_pkg.sv
// draw_arbiter_pkg: shared widths, screen geometry, FSM encoding and timeout default
package draw_arbiter_pkg;
  localparam int X_W         = 8;
  localparam int Y_W         = 7;
  localparam int C_W         = 3;
  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int TIMEOUT_DEF = 100000;
  localparam int CNT_W       = 17;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
endpackage

// File: rtl/draw_watchdog.sv
// draw_watchdog: cycle counter that flags when a draw has run TIMEOUT cycles
module draw_watchdog
  import draw_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d   = clear ? '0 : enable ? cnt_q + CNT_W'(1) : cnt_q;
  assign expired = cnt_q == CNT_W'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/draw_arbiter.sv
// draw_arbiter: fixed-priority, non-preemptive arbiter sharing one VGA pixel bus among drawers
module draw_arbiter
  import draw_arbiter_pkg::*;
#(
  parameter int NCLI    = 3,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCLI-1:0]       req,
  output logic [NCLI-1:0]       ack,
  output logic                  err,
  output logic [NCLI-1:0]       begin_draw,
  input  logic [NCLI-1:0]       done_in,
  input  logic [X_W*NCLI-1:0]   x_in,
  input  logic [Y_W*NCLI-1:0]   y_in,
  input  logic [C_W*NCLI-1:0]   color_in,
  input  logic [NCLI-1:0]       draw_in,
  output logic [X_W-1:0]        x_out,
  output logic [Y_W-1:0]        y_out,
  output logic [C_W-1:0]        color_out,
  output logic                  plot,
  output logic                  busy
);
  localparam int SW = NCLI > 1 ? $clog2(NCLI) : 1;
  logic [2:0]      state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d, pick;
  logic            err_q, err_d, expired, plot_d;
  logic [NCLI-1:0] begin_q, grant;
  logic [X_W-1:0]  x_q;
  logic [Y_W-1:0]  y_q;
  logic [C_W-1:0]  c_q;

  draw_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == S_START),
    .enable (state_q == S_WAIT),
    .expired(expired)
  );

  always_comb begin
    pick = '0;
    for (int i = NCLI - 1; i >= 0; i--) if (req[i]) pick = SW'(i);
  end

  assign grant  = NCLI'(1) << sel_q;
  assign plot_d = draw_in[sel_q] & (state_q == S_WAIT);

  // done has priority over a timeout landing in the same cycle
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        sel_d   = |req ? pick : sel_q;
        state_d = |req ? S_START : S_IDLE;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        state_d = done_in[sel_q] || expired ? S_RELEASE : S_WAIT;
        err_d   = !done_in[sel_q] && expired;
      end
      S_RELEASE: state_d = err_q || !done_in[sel_q] ? S_ACK : S_RELEASE;
      S_ACK: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      err_q   <= 1'b0;
      begin_q <= '0;
      plot    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      begin_q <= state_d == S_WAIT ? grant : '0;
      plot    <= plot_d;
      if (plot_d) begin
        x_q <= x_in[X_W*sel_q +: X_W];
        y_q <= y_in[Y_W*sel_q +: Y_W];
        c_q <= color_in[C_W*sel_q +: C_W];
      end
    end
  end

  assign begin_draw = begin_q;
  assign ack        = state_q == S_ACK ? grant : '0;
  assign err        = state_q == S_ACK && err_q;
  assign busy       = state_q != S_IDLE;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign color_out  = c_q;
endmodule
